// File: rtl/mod_mult_seq.sv
// mod_mult_seq: iterative MSB-first (iA*iB) mod iMod, one multiplier bit per clock; option MOD_MULT_SEQ_ZERO_SKIP_EN
module mod_mult_seq #(
  parameter int BITWIDTH = 32
) (
  input  logic                iClk,
  input  logic                iRstN,
  input  logic                iClr,
  input  logic                iStart,
  input  logic [BITWIDTH-1:0] iA,
  input  logic [BITWIDTH-1:0] iB,
  input  logic [BITWIDTH-1:0] iMod,
  output logic                oReady,
  output logic                oValid,
  output logic [BITWIDTH-1:0] oData
);
  localparam int CW = (BITWIDTH > 1) ? $clog2(BITWIDTH) : 1;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;
  localparam logic [CW-1:0] LAST = CW'(BITWIDTH - 1);
  logic [0:0]          r_state;
  logic [BITWIDTH-1:0] r_a, r_b, r_m, r_acc, r_data;
  logic [CW-1:0]       r_cnt;
  logic                r_valid;
  logic [BITWIDTH:0]   w_dbl, w_sum, w_m;
  logic [BITWIDTH-1:0] w_t, w_add, w_u;
  logic                w_zero;
  // Both reductions subtract at BITWIDTH bits: the true difference is < M, so the wrapped low bits are exact.
  always_comb begin
    w_m   = {1'b0, r_m};
    w_dbl = {r_acc, 1'b0};
    w_t   = (w_dbl >= w_m) ? w_dbl[BITWIDTH-1:0] - r_m : w_dbl[BITWIDTH-1:0];
    w_sum = {1'b0, w_t} + {1'b0, r_a};
    w_add = (w_sum >= w_m) ? w_sum[BITWIDTH-1:0] - r_m : w_sum[BITWIDTH-1:0];
    w_u   = r_b[r_cnt] ? w_add : w_t;
  end
`ifdef MOD_MULT_SEQ_ZERO_SKIP_EN
  assign w_zero = (iA == '0) || (iB == '0);
`else
  assign w_zero = 1'b0;
`endif
  always_ff @(posedge iClk) begin
    if (!iRstN || iClr) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_m     <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (r_state == IDLE) begin
        if (iStart && w_zero) begin
          r_data  <= '0;
          r_valid <= 1'b1;
        end else if (iStart) begin
          r_a     <= iA;
          r_b     <= iB;
          r_m     <= iMod;
          r_acc   <= '0;
          r_cnt   <= LAST;
          r_state <= RUN;
        end
      end else begin
        r_acc <= w_u;
        r_cnt <= r_cnt - CW'(1);
        if (r_cnt == '0) begin
          r_data  <= w_u;
          r_valid <= 1'b1;
          r_state <= IDLE;
        end
      end
    end
  end
  assign oReady = (r_state == IDLE);
  assign oValid = r_valid;
  assign oData  = r_data;
endmodule

// File: tb/tb_mod_mult_seq.sv
// tb_mod_mult_seq: scoreboard bench checking result value and arrival cycle of every oValid pulse
module tb_mod_mult_seq;
  localparam int W = 8;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clr = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0, b = '0, m = '0;
  logic         ready, valid;
  logic [W-1:0] data;
  int           errors = 0;
  int           checks = 0;
  int           cyc = 0;
  int           exp_data[$];
  int           exp_cyc[$];

  mod_mult_seq #(.BITWIDTH(W)) dut (
    .iClk(clk), .iRstN(rst_n), .iClr(clr), .iStart(start),
    .iA(a), .iB(b), .iMod(m),
    .oReady(ready), .oValid(valid), .oData(data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && valid) begin
      if (exp_data.size() == 0) check("spurious_valid", 1, 0);
      else begin
        check("data", data, exp_data.pop_front());
        check("latency_cycle", cyc, exp_cyc.pop_front());
      end
    end
  end

  // Called at a negedge; returns at the negedge after the start edge.
  task automatic go(input int ia, input int ib, input int im, input bit push);
    int lat;
    start = 1'b1;
    a = W'(ia);
    b = W'(ib);
    m = W'(im);
    @(posedge clk);
    #1;
`ifdef MOD_MULT_SEQ_ZERO_SKIP_EN
    lat = (ia == 0 || ib == 0) ? 1 : W;
`else
    lat = W;
`endif
    if (push) begin
      exp_data.push_back((ia * ib) % im);
      exp_cyc.push_back(cyc + lat);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_data.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (exp_data.size() != 0) check("timeout", exp_data.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_data", data, 0);
    check("rst_valid", valid, 0);
    check("rst_ready", ready, 1);
    rst_n = 1'b1;
    @(negedge clk);
    go(5, 7, 11, 1);
    repeat (3) @(negedge clk);
    check("ready_in_run", ready, 0);
    drain();
    check("hold_t1", data, 2);
    go(254, 254, 255, 1);
    repeat (8) @(negedge clk);
    check("ready_at_valid", ready, 1);
    go(10, 10, 11, 1);
    repeat (4) @(negedge clk);
    check("hold_between", data, 1);
    drain();
    go(0, 9, 13, 1);
    drain();
    go(6, 5, 7, 1);
    @(negedge clk);
    go(1, 1, 7, 0);
    drain();
    check("ignored_start", data, 2);
    go(3, 4, 5, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_data", data, 0);
    check("abort_ready", ready, 1);
    repeat (12) @(negedge clk);
    check("abort_novalid", data, 0);
    go(3, 4, 5, 1);
    drain();
    go(3, 4, 5, 0);
    clr = 1'b1;
    go(4, 4, 5, 0);
    clr = 1'b0;
    check("clr_data", data, 0);
    check("clr_ready", ready, 1);
    repeat (12) @(negedge clk);
    check("clr_novalid", data, 0);
    check("clr_ready_after", ready, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mod_mult_seq.md
Name: mod_mult_seq

Overview:
Iterative modular multiplier that computes (iA * iB) mod iMod using MSB-first interleaved shift-and-add, one multiplier bit per clock. It sits directly upstream of the registered modular adder stage and produces the products that stage accumulates. It uses the same operand/modulus conventions: operands already reduced (< iMod), with a start/valid handshake in place of a free-running enable.

Parameters:
BITWIDTH, 32, width of operands, modulus and result

Ports:
iClk  input  1  clock, rising edge
iRstN  input  1  synchronous active-low reset
iClr  input  1  synchronous clear/abort, lower priority than iRstN
iStart  input  1  start request; accepted only when oReady=1
iA  input  BITWIDTH  multiplicand, required < iMod
iB  input  BITWIDTH  multiplier, required < iMod
iMod  input  BITWIDTH  modulus, required >= 2
oReady  output  1  high in IDLE; a new iStart is accepted
oValid  output  1  one-cycle pulse: oData holds a new result
oData  output  BITWIDTH  registered product mod iMod

Behaviour:
- Clock and reset: one clock iClk. Reset iRstN is synchronous and active-low. Both are fixed.
- Reset (iRstN=0 at an edge): state=IDLE, oData=0, oValid=0, oReady=1. The accumulator, counter and operand registers are cleared. Reset mid-operation abandons the computation; no oValid.
- iClr=1 (iRstN=1): same effect as reset. An iStart in the same cycle is ignored.
- States: IDLE, RUN.
- IDLE: oReady=1. iStart=1 at edge E:
  - latch iA, iB, iMod into internal registers
  - acc=0, bit index cnt=BITWIDTH-1
  - go to RUN
- RUN: oReady=0. iStart is ignored and the inputs are not sampled. At each edge:
  - t = 2*acc, computed at BITWIDTH+1 bits; if t >= M then t = t - M
  - if B[cnt]=1: u = t + A, computed at BITWIDTH+1 bits; if u >= M then u = u - M; else u = t
  - acc = u, cnt = cnt-1
- Completion:
  - When cnt==0 at an edge, u is written to oData, oValid=1 for the following cycle only, and state returns to IDLE.
  - Latency: oValid is high in the cycle after edge E+BITWIDTH, i.e. exactly BITWIDTH edges after the start edge.
  - oReady is high in that same cycle, so back-to-back starts give one result per BITWIDTH cycles.
- oData holds its value until the next completion, reset or clear. oValid is 0 at all other times.
- Arithmetic: every intermediate value is < 2*M, so a single conditional subtract suffices. No BITWIDTH-bit overflow is permitted; internal adders are BITWIDTH+1 wide.
- Operands violating the preconditions (A >= M, B >= M, M < 2): the result is unspecified, but the FSM timing is unchanged and no lockup occurs.
- Simultaneous iStart and oValid cycle: legal. The new operation starts and the old result remains on oData until the new one completes.

Optional Feature:
MOD_MULT_SEQ_ZERO_SKIP_EN
- Defined: in IDLE, if iStart=1 and (iA==0 or iB==0), the block stays in IDLE, writes oData=0 and pulses oValid in the next cycle, giving latency 1.
- Undefined: zero operands take the full BITWIDTH-cycle RUN path and produce 0.

Test Plan:
1. BITWIDTH=8, A=5, B=7, M=11; pulse iStart -> oValid exactly 8 cycles after the start edge, oData=2. oReady=0 during those cycles.
2. A=254, B=254, M=255 (overflow corner) -> oData=1. Then back-to-back A=10, B=10, M=11 started in the oValid cycle -> second oValid 8 cycles later, oData=1. oData stays 1 between the two results.
3. A=0, B=9, M=13 -> oData=0. Latency is 8 without the macro and 1 with MOD_MULT_SEQ_ZERO_SKIP_EN.
4. Start A=6, B=5, M=7, and pulse iStart again at cycle 3 with A=1, B=1 -> second start ignored. oData=2 at cycle 8, exactly one oValid pulse.
5. Start A=3, B=4, M=5, assert iRstN=0 at cycle 4 -> oValid never pulses, oData=0, oReady=1 after the reset edge. A restart with the same operands gives oData=2.
6. Start, then iClr=1 together with iStart at cycle 2 -> abort, IDLE, oData=0, no oValid, new start ignored.
